// File: rtl/bit_fifo_gen.sv
// -----------------------------------------------------------------------------
// bit_fifo_gen
//
// Word-in / variable-bit-out FIFO. Full IN_W-bit words are pushed in and
// fields of 0..OUT_W bits are pulled out LSB-first (bit 0 of the first pushed
// word is the oldest bit). Storage is a circular bit buffer of DEPTH*IN_W
// bits, held as DEPTH words with a word-granular write pointer and a
// bit-granular read pointer (kept as word index + bit offset so that IN_W
// need not be a power of two).
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-high reset
//   i_pushin    write strobe; i_datain captured when i_pushin=1 and o_full=0
//   i_datain    write word, bit 0 oldest
//   o_full      high when free bits < IN_W
//   o_overflow  sticky; set by a push attempt while full
//   i_reqin     read-request strobe
//   i_reqlen    requested field length (0..OUT_W)
//   o_level     number of stored, unread bits
//   o_pushout   response strobe, one per request, two cycles after sampling
//   o_errout    qualifies o_pushout: request rejected
//   o_lenout    echo of the request length
//   o_dataout   field, oldest bit at [0], bits >= o_lenout are zero
// -----------------------------------------------------------------------------
module bit_fifo_gen #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 15,
  parameter int DEPTH = 32,
  parameter int LEN_W = 4,
  parameter int LVL_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pushin,
  input  logic [IN_W-1:0]  i_datain,
  output logic             o_full,
  output logic             o_overflow,
  input  logic             i_reqin,
  input  logic [LEN_W-1:0] i_reqlen,
  output logic [LVL_W-1:0] o_level,
  output logic             o_pushout,
  output logic             o_errout,
  output logic [LEN_W-1:0] o_lenout,
  output logic [OUT_W-1:0] o_dataout
);

  localparam int CAP   = DEPTH * IN_W;
  localparam int WA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OFF_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int PI_W  = $clog2(2 * IN_W);
  localparam int SUM_W = ((OFF_W > LEN_W) ? OFF_W : LEN_W) + 1;

  localparam logic [LVL_W-1:0] IN_W_L   = LVL_W'(IN_W);
  localparam logic [LVL_W-1:0] FULL_THR = LVL_W'(CAP - IN_W);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  r_mem [DEPTH];
  logic [WA_W-1:0]  r_wr_ptr;
  logic [WA_W-1:0]  r_rd_word;
  logic [OFF_W-1:0] r_rd_off;
  logic [LVL_W-1:0] r_level;
  logic             r_full;
  logic             r_overflow;

  // Response pipeline: stage 1 holds the extracted field, stage 2 delays it,
  // the output register presents it.
  logic             r_s1_vld;
  logic             r_s1_err;
  logic [LEN_W-1:0] r_s1_len;
  logic [OUT_W-1:0] r_s1_data;
  logic             r_s2_vld;
  logic             r_s2_err;
  logic [LEN_W-1:0] r_s2_len;
  logic [OUT_W-1:0] r_s2_data;
  logic             r_pushout;
  logic             r_errout;
  logic [LEN_W-1:0] r_lenout;
  logic [OUT_W-1:0] r_dataout;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic             w_push;
  logic             w_len_ok;
  logic             w_lvl_ok;
  logic             w_accept;
  logic [LVL_W-1:0] w_level_next;
  logic             w_full_next;

  // Push and request acceptance both look at the pre-cycle level/full, so a
  // same-cycle read never makes room for a same-cycle push and a same-cycle
  // push never supplies bits for a same-cycle request.
  assign w_push   = i_pushin & ~r_full;
  assign w_len_ok = ({1'b0, i_reqlen} <= (LEN_W+1)'(OUT_W));
  assign w_lvl_ok = (LVL_W'(i_reqlen) <= r_level);
  assign w_accept = i_reqin & w_len_ok & w_lvl_ok;

  assign w_level_next = r_level
                      + (w_push   ? IN_W_L            : '0)
                      - (w_accept ? LVL_W'(i_reqlen)  : '0);
  assign w_full_next  = (w_level_next > FULL_THR);

  // ---------------------------------------------------------------------------
  // Read pointer advance: offset + len can pass at most one word boundary
  // because len <= OUT_W <= IN_W.
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] w_off_sum;
  logic [OFF_W-1:0] w_rd_off_next;
  logic [WA_W-1:0]  w_rd_word_next;

  assign w_off_sum = SUM_W'(r_rd_off) + SUM_W'(i_reqlen);

  always_comb begin
    w_rd_off_next  = OFF_W'(w_off_sum);
    w_rd_word_next = r_rd_word;
    if (w_off_sum >= SUM_W'(IN_W)) begin
      w_rd_off_next  = OFF_W'(w_off_sum - SUM_W'(IN_W));
      w_rd_word_next = r_rd_word + WA_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Field extraction. A field touches at most the current word and the next
  // one; the next-word index wraps modulo DEPTH, which is what stitches the
  // tail of the last word to the head of word 0.
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]   w_lo_word;
  logic [IN_W-1:0]   w_hi_word;
  logic [2*IN_W-1:0] w_pair;
  logic [OUT_W-1:0]  w_raw;
  logic [OUT_W-1:0]  w_mask;
  logic [OUT_W-1:0]  w_field;

  assign w_lo_word = r_mem[r_rd_word];
  assign w_hi_word = r_mem[r_rd_word + WA_W'(1)];
  assign w_pair    = {w_hi_word, w_lo_word};

  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_field_bit
      assign w_raw[gi]  = w_pair[PI_W'(r_rd_off) + PI_W'(gi)];
      assign w_mask[gi] = ({1'b0, i_reqlen} > (LEN_W+1)'(gi));
    end
  endgenerate

  // Rejected requests report an all-zero field.
  assign w_field = w_accept ? (w_raw & w_mask) : '0;

  // ---------------------------------------------------------------------------
  // Storage (no reset: contents are don't-care after reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_datain;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, level, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_word  <= '0;
      r_rd_off   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + WA_W'(1);
      end
      if (w_accept) begin
        r_rd_word <= w_rd_word_next;
        r_rd_off  <= w_rd_off_next;
      end
      if (i_pushin && r_full) begin
        r_overflow <= 1'b1;
      end
      r_level <= w_level_next;
      r_full  <= w_full_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_err  <= 1'b0;
      r_s1_len  <= '0;
      r_s1_data <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_err  <= 1'b0;
      r_s2_len  <= '0;
      r_s2_data <= '0;
    end else begin
      r_s1_vld <= i_reqin;
      r_s1_err <= i_reqin & ~w_accept;
      if (i_reqin) begin
        r_s1_len  <= i_reqlen;
        r_s1_data <= w_field;
      end
      r_s2_vld <= r_s1_vld;
      r_s2_err <= r_s1_err;
      if (r_s1_vld) begin
        r_s2_len  <= r_s1_len;
        r_s2_data <= r_s1_data;
      end
    end
  end

  // lenout/dataout hold between responses; errout is only ever high together
  // with pushout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pushout <= 1'b0;
      r_errout  <= 1'b0;
      r_lenout  <= '0;
      r_dataout <= '0;
    end else begin
      r_pushout <= r_s2_vld;
      r_errout  <= r_s2_vld & r_s2_err;
      if (r_s2_vld) begin
        r_lenout  <= r_s2_len;
        r_dataout <= r_s2_data;
      end
    end
  end

  assign o_full     = r_full;
  assign o_overflow = r_overflow;
  assign o_level    = r_level;
  assign o_pushout  = r_pushout;
  assign o_errout   = r_errout;
  assign o_lenout   = r_lenout;
  assign o_dataout  = r_dataout;

endmodule
